cpu_boot_ctrl: RTL and testbench
================================

// Module: cpu_boot_ctrl
// PURPOSE
//  Boot/run sequencer for the cpu core. Receives a program as a byte stream and writes it into instruction RAM.
//  Holds the cpu in reset while loading, then releases it and gates execution via setn.
//  Stops the cpu on halt (inst==0 or pc saturated) or on a cycle-budget timeout, and reports status to the host.
// PARAMETERS
//  IMSB    15    instruction word MSB (program words are IMSB+1 = 16 bits, sent as 2 bytes)
//  PMSB    7     program-counter / imem address MSB
//  CMSB    15    run-cycle counter MSB
//  MAXCYC  1000  run-cycle budget; must satisfy 1 <= MAXCYC <= 2^(CMSB+1)-1
// PORTS
//  clk        in   1       clock; all flops on posedge
//  rstn       in   1       synchronous active-low reset
//  start      in   1       begin load+run; honoured in IDLE, DONE, TIMEOUT only
//  abort      in   1       return to IDLE from any state
//  s_valid    in   1       program byte valid
//  s_data     in   8       program byte
//  s_ready    out  1       byte accepted when s_valid && s_ready
//  imem_we    out  1       instruction RAM write strobe (registered)
//  imem_addr  out  PMSB+1  instruction RAM write address (registered)
//  imem_wdata out  IMSB+1  instruction RAM write data (registered)
//  pc         in   PMSB+1  cpu program counter
//  inst       in   IMSB+1  instruction currently presented to the cpu
//  cpu_rstn   out  1       cpu reset, active low (registered)
//  cpu_setn   out  1       cpu run enable (registered)
//  busy       out  1       state is not IDLE, DONE or TIMEOUT
//  done       out  1       halted normally; sticky until start, abort or rstn
//  timeout    out  1       budget exhausted; sticky until start, abort or rstn
//  cycles     out  CMSB+1  RUN cycles elapsed; frozen in DONE/TIMEOUT
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - State goes to IDLE.
//   - All outputs 0, including cpu_rstn=0, cpu_setn=0 and imem_*=0.
//  FSM: IDLE, LEN, LO, HI, RELEASE, RUN, DONE, TIMEOUT.
//   - IDLE: s_ready=0, cpu_rstn=0, cpu_setn=0. start -> LEN.
//   - LEN: s_ready=1.
//     - On handshake, capture N=s_data and clear the word index.
//     - N==0 -> RELEASE (existing RAM contents run); otherwise -> LO.
//   - LO: s_ready=1. On handshake, latch the low byte -> HI.
//   - HI: s_ready=1. On handshake:
//     - Next cycle: imem_we=1 for exactly one cycle, imem_addr=index[PMSB:0], imem_wdata={s_data, low byte}.
//     - index increments. index==N-1 -> RELEASE, else -> LO.
//     - Addresses wrap modulo 2^(PMSB+1).
//   - RELEASE: cpu_rstn=1, cpu_setn=0 for one cycle. cycles is cleared. -> RUN.
//   - RUN: cpu_setn=1; cycles increments by 1 every RUN cycle.
//     - Halt = (inst=={IMSB+1{1'b0}}) || (pc=={PMSB+1{1'b1}}), evaluated combinationally each RUN cycle.
//     - On halt: -> DONE. cycles includes the detection cycle.
//     - Else if cycles+1==MAXCYC: -> TIMEOUT. cycles ends at MAXCYC.
//     - Halt has priority over timeout in the same cycle.
//     - cpu_setn is registered, so it drops the cycle after detection; the cpu completes the detection-cycle edge.
//   - DONE / TIMEOUT: cpu_setn=0, cpu_rstn stays 1 (cpu state remains inspectable).
//     - done=1 (resp. timeout=1).
//     - start -> LEN, which clears done, timeout and cycles and drives cpu_rstn=0.
//  Handshakes:
//   - s_ready depends only on state.
//   - With s_valid=0 the FSM waits indefinitely; no writes occur during gaps.
//  Priority:
//   - rstn > abort > all state transitions.
//   - abort goes to IDLE next cycle: clears done, timeout, busy and cpu_*; cycles is held.
//   - A pending imem_we write is suppressed.
//  start while busy is ignored. cycles never wraps (the MAXCYC bound guarantees this).
// TESTING
//  1. start; bytes 03,34,12,CD,AB,00,00 -> imem writes (0,1234),(1,ABCD),(2,0000); cpu_rstn=1 the cycle after the last write; cpu_setn=1 one cycle later.
//  2. Same program with s_valid low 3 cycles between every byte -> identical writes in order; no imem_we during gaps; s_ready=1 throughout LEN/LO/HI.
//  3. In RUN, drive inst=0001 for 5 cycles, then inst=0000 -> done=1, cycles=6, cpu_setn=0 on the next cycle.
//  4. MAXCYC=10; inst nonzero, pc<FF -> timeout=1 after 10 RUN cycles, cycles=10. Then pc=FF and inst=0 on cycle 10 together -> done=1, timeout=0.
//  5. Byte 00 in LEN -> no imem_we; RELEASE then RUN. Then start from DONE -> done cleared, cpu_rstn=0, state LEN.
//  6. abort after 3 bytes of a load -> IDLE next cycle, no imem_we, busy=0. rstn=0 mid-RUN -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_boot_ctrl
//  Description : Boot/run sequencer for the cpu core. Loads a length-prefixed
//                byte stream into instruction RAM as 16-bit little-endian
//                words while holding the cpu in reset. It then releases the
//                cpu, gates execution through setn and stops it on halt or on
//                a run-cycle budget timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_ctrl #(
    parameter int IMSB   = 15,
    parameter int PMSB   = 7,
    parameter int CMSB   = 15,
    parameter int MAXCYC = 1000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic            imem_we,
    output logic [PMSB:0]   imem_addr,
    output logic [IMSB:0]   imem_wdata,
    input  logic [PMSB:0]   pc,
    input  logic [IMSB:0]   inst,
    output logic            cpu_rstn,
    output logic            cpu_setn,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [CMSB:0]   cycles
);

    localparam int            c_IW      = IMSB + 1;
    localparam int            c_AW      = PMSB + 1;
    localparam int            c_CW      = CMSB + 1;
    localparam logic [CMSB:0] c_MAXCYC  = c_CW'(MAXCYC);
    localparam logic [CMSB:0] c_CYC_ONE = c_CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_LO      = 3'd2,
        ST_HI      = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RUN     = 3'd5,
        ST_DONE    = 3'd6,
        ST_TIMEOUT = 3'd7
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           w_s_ready;
    logic           w_hs;
    logic           w_halt;
    logic           w_last_word;
    logic [CMSB:0]  w_cyc_inc;
    logic [15:0]    w_word;
    logic           w_cpu_rstn_nxt;
    logic           w_cpu_setn_nxt;

    logic [7:0]     r_len;
    logic [7:0]     r_index;
    logic [7:0]     r_lo;
    logic           r_imem_we;
    logic [PMSB:0]  r_imem_addr;
    logic [IMSB:0]  r_imem_wdata;
    logic           r_cpu_rstn;
    logic           r_cpu_setn;
    logic [CMSB:0]  r_cycles;

    // The byte stream is only accepted in the three loading states.
    assign w_s_ready   = (r_state == ST_LEN) || (r_state == ST_LO) || (r_state == ST_HI);
    assign w_hs        = s_valid && w_s_ready;
    assign w_halt      = (inst == '0) || (pc == '1);
    assign w_last_word = (r_index == (r_len - 8'd1));
    assign w_cyc_inc   = r_cycles + c_CYC_ONE;
    assign w_word      = {s_data, r_lo};

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the next values of the registered cpu controls.
    // The cpu controls follow the next state so they line up with the state
    // they belong to (setn drops right after the halt-detection edge).
    always_comb begin
        w_state_nxt    = r_state;
        w_cpu_rstn_nxt = 1'b0;
        w_cpu_setn_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (w_hs) begin
                    // A zero length runs whatever is already in the RAM.
                    w_state_nxt = (s_data == 8'h00) ? ST_RELEASE : ST_LO;
                end
            end
            ST_LO: begin
                if (w_hs) w_state_nxt = ST_HI;
            end
            ST_HI: begin
                if (w_hs) w_state_nxt = w_last_word ? ST_RELEASE : ST_LO;
            end
            ST_RELEASE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Halt wins over a simultaneous budget expiry.
                if (w_halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_cyc_inc == c_MAXCYC) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start) w_state_nxt = ST_LEN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (abort) w_state_nxt = ST_IDLE;

        // cpu stays out of reset after a stop so its state can be inspected.
        w_cpu_rstn_nxt = (w_state_nxt == ST_RELEASE) || (w_state_nxt == ST_RUN) ||
                         (w_state_nxt == ST_DONE)    || (w_state_nxt == ST_TIMEOUT);
        w_cpu_setn_nxt = (w_state_nxt == ST_RUN);
    end

    // Capture the program length and the low byte of each word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len   <= 8'h00;
            r_index <= 8'h00;
            r_lo    <= 8'h00;
        end else if (!abort && w_hs) begin
            case (r_state)
                ST_LEN: begin
                    r_len   <= s_data;
                    r_index <= 8'h00;
                end
                ST_LO: begin
                    r_lo <= s_data;
                end
                ST_HI: begin
                    r_index <= r_index + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction RAM write port: one strobe per completed word, dropped on abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (!abort && w_hs && (r_state == ST_HI)) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= c_AW'(r_index);
                r_imem_wdata <= c_IW'(w_word);
            end
        end
    end

    // Registered cpu reset and run enable.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cpu_rstn <= 1'b0;
            r_cpu_setn <= 1'b0;
        end else begin
            r_cpu_rstn <= w_cpu_rstn_nxt;
            r_cpu_setn <= w_cpu_setn_nxt;
        end
    end

    // Run-cycle counter: cleared on a new start and on release, counts every
    // RUN cycle including the stopping one, and is held through abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cycles <= '0;
        end else if (!abort) begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) r_cycles <= '0;
                end
                ST_RELEASE: begin
                    r_cycles <= '0;
                end
                ST_RUN: begin
                    r_cycles <= w_cyc_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready    = w_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rstn   = r_cpu_rstn;
    assign cpu_setn   = r_cpu_setn;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_TIMEOUT);
    assign done       = (r_state == ST_DONE);
    assign timeout    = (r_state == ST_TIMEOUT);
    assign cycles     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_boot_ctrl
//  Description : Self-checking bench for cpu_boot_ctrl with a byte-count
//                based reference model and directed load/run scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_ctrl;

    localparam int MAXCYC = 10;

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        s_valid    = 1'b0;
    logic [7:0]  s_data     = 8'h00;
    logic [7:0]  pc         = 8'h00;
    logic [15:0] inst       = 16'h0001;
    logic        s_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rstn;
    logic        cpu_setn;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int checks = 0;
    int errors = 0;

    logic [23:0] wlog[$];

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .IMSB   (15),
        .PMSB   (7),
        .CMSB   (15),
        .MAXCYC (MAXCYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .pc         (pc),
        .inst       (inst),
        .cpu_rstn   (cpu_rstn),
        .cpu_setn   (cpu_setn),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the load is tracked as a count of accepted bytes
    // (byte 0 = length, odd = low byte, even >= 2 = high byte of word k/2-1).
    localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3, M_DONE = 4, M_TO = 5;
    int          m_mode   = M_IDLE;
    int          m_k      = 0;
    int          m_n      = 0;
    int          m_cycles = 0;
    logic [7:0]  m_lo     = 8'h00;
    logic        e_we     = 1'b0;
    logic [7:0]  e_addr   = 8'h00;
    logic [15:0] e_wdata  = 16'h0000;

    always @(posedge clk) begin : p_model
        bit hs;
        hs   = s_valid && (m_mode == M_LOAD);
        e_we = 1'b0;
        if (!rstn) begin
            m_mode = M_IDLE; m_k = 0; m_n = 0; m_cycles = 0; m_lo = 8'h00;
            e_addr = 8'h00; e_wdata = 16'h0000;
        end else if (abort) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE, M_TO: if (start) begin m_mode = M_LOAD; m_k = 0; m_cycles = 0; end
                M_LOAD: if (hs) begin
                    if (m_k == 0) begin
                        m_n = int'(s_data);
                        if (m_n == 0) m_mode = M_REL;
                    end else if (m_k % 2 == 1) begin
                        m_lo = s_data;
                    end else begin
                        e_we    = 1'b1;
                        e_addr  = 8'((m_k / 2 - 1) % 256);
                        e_wdata = {s_data, m_lo};
                        if (m_k == 2 * m_n) m_mode = M_REL;
                    end
                    m_k++;
                end
                M_REL: begin m_cycles = 0; m_mode = M_RUN; end
                M_RUN: begin
                    m_cycles++;
                    if (inst == 16'h0000 || pc == 8'hFF) m_mode = M_DONE;
                    else if (m_cycles == MAXCYC)         m_mode = M_TO;
                end
                default: ;
            endcase
        end
    end

    // Compare every cycle shortly after the edge; also log observed writes.
    always @(posedge clk) begin : p_cmp
        #1;
        chk("s_ready",    s_ready,    m_mode == M_LOAD);
        chk("busy",       busy,       m_mode == M_LOAD || m_mode == M_REL || m_mode == M_RUN);
        chk("done",       done,       m_mode == M_DONE);
        chk("timeout",    timeout,    m_mode == M_TO);
        chk("cpu_rstn",   cpu_rstn,   m_mode == M_REL || m_mode == M_RUN || m_mode == M_DONE || m_mode == M_TO);
        chk("cpu_setn",   cpu_setn,   m_mode == M_RUN);
        chk("cycles",     cycles,     32'(m_cycles));
        chk("imem_we",    imem_we,    e_we);
        chk("imem_addr",  imem_addr,  e_addr);
        chk("imem_wdata", imem_wdata, e_wdata);
        if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_byte: s_ready=%b after 20 cycles, expected 1", s_ready);
        end
        @(negedge clk);
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return cpu_setn;
            1:       return done;
            default: return timeout;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel, input int limit);
        int t;
        t = 0;
        while (sel_sig(sel) !== 1'b1 && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (sel_sig(sel) !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: still %b after %0d cycles, expected 1", nm, sel_sig(sel), limit);
        end
    endtask

    task automatic chk_log(input string nm);
        logic [23:0] exp_w [3];
        exp_w = '{24'h001234, 24'h01ABCD, 24'h020000};
        chk({nm, "_count"}, wlog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wlog.size()) chk(nm, wlog[i], exp_w[i]);
        end
    endtask

    initial begin : p_main
        logic [7:0] prog [7];
        prog = '{8'h03, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h00};

        // Reset
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rstn", cpu_rstn, 0);
        chk("rst_cpu_setn", cpu_setn, 0);
        chk("rst_imem_we",  imem_we,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_s_ready",  s_ready,  0);
        rstn = 1'b1;
        @(negedge clk);

        // Back-to-back load of three words, then run and halt after 6 cycles
        wlog.delete();
        inst = 16'h0001; pc = 8'h00;
        pulse_start();
        chk("t1_s_ready_len", s_ready, 1);
        foreach (prog[i]) send_byte(prog[i], 0);
        s_valid = 1'b0;
        chk("t1_last_we",     imem_we,  1);
        chk("t1_rel_rstn",    cpu_rstn, 1);
        chk("t1_rel_setn",    cpu_setn, 0);
        chk_log("t1_write");
        @(negedge clk);
        chk("t1_run_setn",    cpu_setn, 1);
        repeat (5) @(negedge clk);
        inst = 16'h0000;
        @(negedge clk);
        chk("t3_done",   done,     1);
        chk("t3_cycles", cycles,   6);
        chk("t3_setn",   cpu_setn, 0);
        chk("t3_rstn",   cpu_rstn, 1);

        // Same program with 3-cycle gaps; halts in the first RUN cycle
        wlog.delete();
        pulse_start();
        foreach (prog[i]) send_byte(prog[i], 3);
        s_valid = 1'b0;
        wait_for("t2_wait_done", 1, 20);
        chk_log("t2_write");
        chk("t2_cycles", cycles, 1);

        // Zero-length load and budget timeout
        wlog.delete();
        inst = 16'h0001;
        pulse_start();
        send_byte(8'h00, 0);
        s_valid = 1'b0;
        wait_for("t4_wait_timeout", 2, 40);
        chk("t4_timeout", timeout, 1);
        chk("t4_cycles",  cycles,  10);
        chk("t4_done",    done,    0);

        // Halt coinciding with the last budget cycle wins over timeout
        pulse_start();
        chk("t4_to_clear", timeout, 0);
        send_byte(8'h00, 0);
        s_valid = 1'b0;
        wait_for("t4_wait_setn", 0, 10);
        repeat (9) @(negedge clk);
        pc = 8'hFF; inst = 16'h0000;
        @(negedge clk);
        chk("t4b_done",    done,    1);
        chk("t4b_timeout", timeout, 0);
        chk("t4b_cycles",  cycles,  10);
        pc = 8'h00; inst = 16'h0001;
        chk("t5_no_write", wlog.size(), 0);

        // Restart from DONE
        pulse_start();
        chk("t5_done_clr", done,     0);
        chk("t5_cpu_rstn", cpu_rstn, 0);
        chk("t5_s_ready",  s_ready,  1);
        chk("t5_cycles",   cycles,   0);

        // Abort coinciding with the third byte suppresses the write
        wlog.delete();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        s_valid = 1'b1; s_data = 8'h22; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; s_valid = 1'b0;
        chk("t6_busy",    busy,        0);
        chk("t6_we",      imem_we,     0);
        chk("t6_nolog",   wlog.size(), 0);
        chk("t6_s_ready", s_ready,     0);

        // Reset in the middle of RUN
        pulse_start();
        send_byte(8'h00, 0);
        s_valid = 1'b0;
        wait_for("t6_wait_setn", 0, 10);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_setn",   cpu_setn, 0);
        chk("t6_rst_rstn",   cpu_rstn, 0);
        chk("t6_rst_busy",   busy,     0);
        chk("t6_rst_cycles", cycles,   0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, expected the scenario list to complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
